// File: rtl/axi_lite_master_arb_if.sv
// AXI4-Lite bus bundle shared between the arbiter (master) and the interconnect (slave).
// Signals: AW/W/B write channels, AR/R read channels, no clock (owned by the parent).
interface axi_lite_master_arb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_master_arb.sv
// Round-robin arbiter that serialises single-word commands from NREQ requesters
// onto one AXI4-Lite master port, one transaction at a time, with a hung-slave watchdog.
// Ports: axi_aclk/axi_reset (sync, active-high); req_* command ports (valid/ready,
// ready is a same-cycle combinational grant); resp_* one-cycle completion pulse;
// timeout_flag sticky watchdog indicator; m_axi AXI4-Lite master bundle.
module axi_lite_master_arb #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                                axi_aclk,
  input  logic                                axi_reset,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0]                     req_we,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [NREQ-1:0][31:0]               req_wdata,
  input  logic [NREQ-1:0][3:0]                req_wstrb,
  output logic [NREQ-1:0]                     resp_valid,
  output logic [31:0]                         resp_rdata,
  output logic                                resp_err,
  output logic                                timeout_flag,
  axi_lite_master_arb_if.master               m_axi
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state, state_nxt;
  logic [IW-1:0]         rr_ptr, ptr_nxt;
  logic [IW-1:0]         gnt, gnt_nxt;
  logic [CW-1:0]         wd_cnt, wd_nxt;
  logic                  awvalid_q, awvalid_nxt, wvalid_q, wvalid_nxt, arvalid_q, arvalid_nxt;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_nxt, araddr_q, araddr_nxt;
  logic [31:0]           wdata_q, wdata_nxt, rdata_nxt;
  logic [3:0]            wstrb_q, wstrb_nxt;
  logic                  err_nxt, tflag_nxt, abort, wd_expired;
  logic [NREQ-1:0]       resp_valid_nxt;
  logic                  any_req;
  logic [IW-1:0]         pick;
  int unsigned           scan_idx;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = DATA_WIDTH'(wdata_q);
  assign m_axi.wstrb   = (DATA_WIDTH/8)'(wstrb_q);
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state == S_WRESP);
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state == S_RDATA);

  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

  // First valid requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    any_req  = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!any_req && req_valid[IW'(scan_idx)]) begin
        any_req = 1'b1;
        pick    = IW'(scan_idx);
      end
    end
  end

  // Grant is combinational so the command is accepted in the same IDLE cycle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !axi_reset && any_req) req_ready[pick] = 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = rr_ptr;
    gnt_nxt        = gnt;
    wd_nxt         = wd_cnt;
    awvalid_nxt    = awvalid_q;
    wvalid_nxt     = wvalid_q;
    arvalid_nxt    = arvalid_q;
    awaddr_nxt     = awaddr_q;
    araddr_nxt     = araddr_q;
    wdata_nxt      = wdata_q;
    wstrb_nxt      = wstrb_q;
    rdata_nxt      = resp_rdata;
    err_nxt        = resp_err;
    tflag_nxt      = timeout_flag;
    resp_valid_nxt = '0;
    abort          = 1'b0;

    case (state)
      S_IDLE: begin
        if (any_req) begin
          gnt_nxt = pick;
          ptr_nxt = (pick == IW'(NREQ - 1)) ? '0 : IW'(pick + 1'b1);
          if (req_we[pick]) begin
            state_nxt   = S_WADDR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            awaddr_nxt  = req_addr[pick];
            wdata_nxt   = req_wdata[pick];
            wstrb_nxt   = req_wstrb[pick];
          end else begin
            state_nxt   = S_RADDR;
            arvalid_nxt = 1'b1;
            araddr_nxt  = req_addr[pick];
          end
        end
      end
      S_WADDR: begin
        // AW and W retire independently; a dropped valid means that beat is done.
        if (awvalid_q && m_axi.awready) awvalid_nxt = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_nxt  = 1'b0;
        if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) state_nxt = S_WRESP;
        else if (wd_expired) abort = 1'b1;
      end
      S_WRESP: begin
        if (m_axi.bvalid) begin
          state_nxt = S_DONE;
          err_nxt   = (m_axi.bresp != 2'b00);
        end else if (wd_expired) abort = 1'b1;
      end
      S_RADDR: begin
        if (m_axi.arready) begin
          arvalid_nxt = 1'b0;
          state_nxt   = S_RDATA;
        end else if (wd_expired) abort = 1'b1;
      end
      S_RDATA: begin
        if (m_axi.rvalid) begin
          state_nxt = S_DONE;
          rdata_nxt = 32'(m_axi.rdata);
          err_nxt   = (m_axi.rresp != 2'b00);
        end else if (wd_expired) abort = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Watchdog abort: release the bus and complete the command as an error.
    if (abort) begin
      awvalid_nxt = 1'b0;
      wvalid_nxt  = 1'b0;
      arvalid_nxt = 1'b0;
      state_nxt   = S_DONE;
      err_nxt     = 1'b1;
      rdata_nxt   = 32'hDEADBEEF;
      tflag_nxt   = 1'b1;
    end

    if (state_nxt == S_DONE && state != S_DONE) resp_valid_nxt[gnt] = 1'b1;

    if (state_nxt != state) wd_nxt = '0;
    else if (state == S_WADDR || state == S_WRESP || state == S_RADDR || state == S_RDATA)
      wd_nxt = CW'(wd_cnt + 1'b1);
  end

  // State and output registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      wd_cnt       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid   <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= ptr_nxt;
      gnt          <= gnt_nxt;
      wd_cnt       <= wd_nxt;
      awvalid_q    <= awvalid_nxt;
      wvalid_q     <= wvalid_nxt;
      arvalid_q    <= arvalid_nxt;
      awaddr_q     <= awaddr_nxt;
      araddr_q     <= araddr_nxt;
      wdata_q      <= wdata_nxt;
      wstrb_q      <= wstrb_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_rdata   <= rdata_nxt;
      resp_err     <= err_nxt;
      timeout_flag <= tflag_nxt;
    end
  end

endmodule
